bus_arbiter: RTL and testbench

- Drives the one-hot `enable` vector of the shared `bus` mux, directly upstream of it.
- Up to COUNT bus sources raise requests. The arbiter grants exactly one at a time, round-robin.
- It inserts a dead (all-zero) turnaround window between owners so two sources never drive the bus together.
- It optionally preempts an owner that holds the bus too long.

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM encodings and counter widths.
package bus_arbiter_pkg;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 4;

    typedef enum logic [1:0] {
        BUS_ARB_IDLE  = 2'd0,
        BUS_ARB_GRANT = 2'd1,
        BUS_ARB_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping.
module rr_pick #(
    parameter int COUNT = 4,
    localparam int IW   = $clog2(COUNT)
) (
    input  logic [COUNT-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [COUNT-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 1; k <= COUNT; k++) begin
            pos = IW'((int'(last) + k) % COUNT);
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
        if (any)
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a dead turnaround window between owners
// and optional hold-time preemption.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int COUNT       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic                     clk_25mhz,
    input  logic                     rst,
    input  logic [COUNT-1:0]         req,
    input  logic                     lock,
    output logic [COUNT-1:0]         grant,
    output logic [$clog2(COUNT)-1:0] grant_idx,
    output logic                     busy
);

    localparam int IW = $clog2(COUNT);

    arb_state_e        state_q, state_d;
    logic [COUNT-1:0]  grant_d;
    logic [IW-1:0]     idx_d;
    logic              busy_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [IW-1:0]     last_q, last_d;

    logic [COUNT-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [COUNT-1:0]  others;
    logic              preempt;
    logic              start;

    rr_pick #(.COUNT(COUNT)) u_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Preemption needs a competing request; a sole requester keeps the bus.
    assign others  = req & ~grant;
    assign preempt = (MAX_HOLD != 0) && (hold_q >= HOLD_W'(MAX_HOLD))
                     && (others != '0) && !lock;

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        idx_d   = grant_idx;
        busy_d  = busy;
        hold_d  = hold_q;
        turn_d  = turn_q;
        last_d  = last_q;
        start   = 1'b0;

        case (state_q)
            BUS_ARB_IDLE: begin
                start = pick_any;
            end
            BUS_ARB_GRANT: begin
                if (!req[grant_idx] || preempt) begin
                    state_d = BUS_ARB_TURN;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    turn_d  = TURN_W'(1);
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            BUS_ARB_TURN: begin
                if (turn_q >= TURN_W'(TURN_CYCLES)) begin
                    state_d = BUS_ARB_IDLE;
                    turn_d  = '0;
                    start   = pick_any;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: state_d = BUS_ARB_IDLE;
        endcase

        if (start) begin
            state_d = BUS_ARB_GRANT;
            grant_d = pick_onehot;
            idx_d   = pick_idx;
            busy_d  = 1'b1;
            hold_d  = HOLD_W'(1);
            last_d  = pick_idx;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q   <= BUS_ARB_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            hold_q    <= '0;
            turn_q    <= '0;
            last_q    <= IW'(COUNT - 1);
        end else begin
            state_q   <= state_d;
            grant     <= grant_d;
            grant_idx <= idx_d;
            busy      <= busy_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            last_q    <= last_d;
        end
    end

    a_grant_onehot0: assert property (@(posedge clk_25mhz) $onehot0(grant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter with a scoreboard queue and gap monitors.
module tb_bus_arbiter;

    logic       clk_25mhz = 1'b0;
    logic       rst, lock, rst3, lock3;
    logic [3:0] req, req3;
    logic [3:0] grant, grant3;
    logic [1:0] grant_idx, grant_idx3;
    logic       busy, busy3;

    int checks = 0;
    int errors = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    bus_arbiter #(.COUNT(4), .TURN_CYCLES(1), .MAX_HOLD(4)) dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    bus_arbiter #(.COUNT(4), .TURN_CYCLES(3), .MAX_HOLD(4)) dut3 (
        .clk_25mhz (clk_25mhz),
        .rst       (rst3),
        .req       (req3),
        .lock      (lock3),
        .grant     (grant3),
        .grant_idx (grant_idx3),
        .busy      (busy3)
    );

    typedef struct {
        string      tag;
        bit         sel3;
        logic       rst;
        logic [3:0] req;
        logic       lock;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] idx;
        bit         chk_idx;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(string tag, bit sel3, logic r, logic [3:0] rq,
                                logic lk, logic [3:0] g, logic [1:0] x);
        vec_t v;
        v.tag     = tag;
        v.sel3    = sel3;
        v.rst     = r;
        v.req     = rq;
        v.lock    = lk;
        v.grant   = g;
        v.busy    = (g != 4'b0000);
        v.idx     = x;
        v.chk_idx = r || (g != 4'b0000);
        return v;
    endfunction

    function automatic void add(string tag, logic r, logic [3:0] rq, logic lk,
                                logic [3:0] g, logic [1:0] x, int n);
        for (int i = 0; i < n; i++)
            vecs.push_back(mk(tag, 1'b0, r, rq, lk, g, x));
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t       e;
        logic [3:0] g;
        logic       b;
        logic [1:0] x;
        if (v.sel3) begin
            rst3 = v.rst; req3 = v.req; lock3 = v.lock;
        end else begin
            rst = v.rst; req = v.req; lock = v.lock;
        end
        sb.push_back(v);
        @(posedge clk_25mhz);
        #1;
        e = sb.pop_front();
        g = e.sel3 ? grant3 : grant;
        b = e.sel3 ? busy3 : busy;
        x = e.sel3 ? grant_idx3 : grant_idx;
        checks++;
        if (g !== e.grant) begin
            errors++;
            $display("FAIL %s grant got %b expected %b", e.tag, g, e.grant);
        end
        checks++;
        if (b !== e.busy) begin
            errors++;
            $display("FAIL %s busy got %b expected %b", e.tag, b, e.busy);
        end
        if (e.chk_idx) begin
            checks++;
            if (x !== e.idx) begin
                errors++;
                $display("FAIL %s grant_idx got %0d expected %0d", e.tag, x, e.idx);
            end
        end
    endtask

    task automatic step3(string tag, logic r, logic [3:0] rq, logic [3:0] g, logic [1:0] x);
        run_vec(mk(tag, 1'b1, r, rq, 1'b0, g, x));
    endtask

    // Gap monitors: a change of owner must be separated by >= TURN_CYCLES idle cycles.
    logic [3:0] prev_g, prev_g3;
    int         zrun, zrun3;

    always @(negedge clk_25mhz) begin
        if (rst !== 1'b0) begin
            prev_g = '0; zrun = 0;
        end else if (grant == 4'b0000) begin
            zrun++;
        end else begin
            if (prev_g != 4'b0000 && grant != prev_g) begin
                checks++;
                if (zrun < 1) begin
                    errors++;
                    $display("FAIL gap1 zero cycles got %0d required >= 1", zrun);
                end
            end
            prev_g = grant; zrun = 0;
        end
    end

    always @(negedge clk_25mhz) begin
        if (rst3 !== 1'b0) begin
            prev_g3 = '0; zrun3 = 0;
        end else if (grant3 == 4'b0000) begin
            zrun3++;
        end else begin
            if (prev_g3 != 4'b0000 && grant3 != prev_g3) begin
                checks++;
                if (zrun3 < 3) begin
                    errors++;
                    $display("FAIL gap3 zero cycles got %0d required >= 3", zrun3);
                end
            end
            prev_g3 = grant3; zrun3 = 0;
        end
    end

    initial begin
        rst = 1'b1; req = '0; lock = 1'b0;
        rst3 = 1'b1; req3 = '0; lock3 = 1'b0;

        // reset and first grant
        add("reset",      1, 4'b1111, 0, 4'b0000, 2'd0, 2);
        add("first",      0, 4'b1111, 0, 4'b0001, 2'd0, 1);
        // fair rotation with MAX_HOLD=4
        add("rot0",       0, 4'b1111, 0, 4'b0001, 2'd0, 3);
        add("turn0",      0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add("rot1",       0, 4'b1111, 0, 4'b0010, 2'd1, 4);
        add("turn1",      0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add("rot2",       0, 4'b1111, 0, 4'b0100, 2'd2, 4);
        add("turn2",      0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add("rot3",       0, 4'b1111, 0, 4'b1000, 2'd3, 4);
        add("turn3",      0, 4'b1111, 0, 4'b0000, 2'd0, 1);
        add("wrap",       0, 4'b1111, 0, 4'b0001, 2'd0, 1);
        add("drain",      0, 4'b0000, 0, 4'b0000, 2'd0, 3);
        // voluntary release, request arriving during TURN
        add("vol",        0, 4'b0100, 0, 4'b0100, 2'd2, 3);
        add("vol_rel",    0, 4'b0000, 0, 4'b0000, 2'd0, 1);
        add("turn_req",   0, 4'b1000, 0, 4'b1000, 2'd3, 1);
        add("turn_rel",   0, 4'b0000, 0, 4'b0000, 2'd0, 2);
        add("lock_idle",  0, 4'b0000, 1, 4'b0000, 2'd0, 1);
        // lock suppresses preemption
        add("lock",       0, 4'b0011, 1, 4'b0001, 2'd0, 10);
        add("unlock",     0, 4'b0011, 0, 4'b0000, 2'd0, 1);
        add("lock_next",  0, 4'b0011, 0, 4'b0010, 2'd1, 1);
        add("lock_drain", 0, 4'b0000, 0, 4'b0000, 2'd0, 2);
        // sole requester is never preempted
        add("sole",       0, 4'b0010, 0, 4'b0010, 2'd1, 20);
        add("sole_drain", 0, 4'b0000, 0, 4'b0000, 2'd0, 2);
        // owner drop coinciding with preemption
        add("pre_hold",   0, 4'b0011, 0, 4'b0001, 2'd0, 4);
        add("pre_drop",   0, 4'b0010, 0, 4'b0000, 2'd0, 1);
        add("pre_next",   0, 4'b0010, 0, 4'b0010, 2'd1, 1);
        add("pre_drain",  0, 4'b0000, 0, 4'b0000, 2'd0, 2);

        foreach (vecs[i]) run_vec(vecs[i]);

        // TURN_CYCLES=3: reset mid-grant and pointer restore
        step3("r6_rst",    1, 4'b0000, 4'b0000, 2'd0);
        step3("r6_g2",     0, 4'b0100, 4'b0100, 2'd2);
        step3("r6_g2b",    0, 4'b0100, 4'b0100, 2'd2);
        step3("r6_mid",    1, 4'b0101, 4'b0000, 2'd0);
        step3("r6_ptr0",   0, 4'b0101, 4'b0001, 2'd0);
        step3("r6_rst2",   1, 4'b0000, 4'b0000, 2'd0);
        step3("r6_g1",     0, 4'b0010, 4'b0010, 2'd1);
        step3("r6_g1b",    0, 4'b0110, 4'b0010, 2'd1);
        step3("r6_mid2",   1, 4'b0110, 4'b0000, 2'd0);
        step3("r6_ptr1",   0, 4'b0110, 4'b0010, 2'd1);
        // exact three-cycle gap between owners
        step3("r6_rel",    0, 4'b0000, 4'b0000, 2'd0);
        step3("r6_t2",     0, 4'b0000, 4'b0000, 2'd0);
        step3("r6_t3",     0, 4'b0000, 4'b0000, 2'd0);
        step3("r6_a",      0, 4'b0011, 4'b0001, 2'd0);
        for (int i = 0; i < 3; i++)
            step3("r6_hold", 0, 4'b0011, 4'b0001, 2'd0);
        for (int i = 0; i < 3; i++)
            step3("r6_gap",  0, 4'b0011, 4'b0000, 2'd0);
        step3("r6_b",      0, 4'b0011, 4'b0010, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
